// File: rtl/wb_slave_mux.sv
// ---------------------------------------------------------------------------
// wb_slave_mux
//
// Single-master, 8-bit classic Wishbone slave multiplexer with a watchdog on
// every transaction. It decodes the upper master address bits into a one-hot
// slave select and registers the shared address, data and write-enable. It
// always returns an ack to the master. A transfer to an unmapped slave, or to
// a slave that never acks, completes with read data 0xFF and sets a sticky
// error flag. This means the upstream EPB cycle can never stall.
//
// Ports:
//   wb_clk_i    - Wishbone clock (single domain)
//   wb_rst_n    - asynchronous, active-low reset
//   m_stb_i     - master strobe (doubles as cycle)
//   m_we_i      - master write enable
//   m_adr_i     - master address; upper bits select the slave
//   m_dat_i     - master write data
//   m_dat_o     - read data returned to the master (held between transfers)
//   m_ack_o     - one-cycle transfer-complete pulse to the master
//   s_cyc_o     - per-slave cycle, one-hot or zero
//   s_stb_o     - per-slave strobe, identical to s_cyc_o
//   s_we_o      - shared slave write enable
//   s_adr_o     - shared slave address (low master address bits)
//   s_dat_o     - shared slave write data
//   s_dat_i     - slave read data, slave k in bits [8k+7:8k]
//   s_ack_i     - per-slave ack
//   err_clr_i   - clears the sticky bus error flag
//   bus_err_o   - sticky bus error flag
//   err_code_o  - last error: 01 = decode error, 10 = timeout
//   err_adr_o   - full master address of the last error
// ---------------------------------------------------------------------------
module wb_slave_mux #(
  parameter int NUM_SLAVES    = 2,
  parameter int ADR_WIDTH     = 5,
  parameter int SLV_ADR_WIDTH = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic                     m_stb_i,
  input  logic                     m_we_i,
  input  logic [ADR_WIDTH-1:0]     m_adr_i,
  input  logic [7:0]               m_dat_i,
  output logic [7:0]               m_dat_o,
  output logic                     m_ack_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [SLV_ADR_WIDTH-1:0] s_adr_o,
  output logic [7:0]               s_dat_o,
  input  logic [8*NUM_SLAVES-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic                     err_clr_i,
  output logic                     bus_err_o,
  output logic [1:0]               err_code_o,
  output logic [ADR_WIDTH-1:0]     err_adr_o
);

  localparam int SEL_W = ADR_WIDTH - SLV_ADR_WIDTH;

  // The watchdog gives up when the counter already holds this value and the
  // selected slave still has not acked. The strobe is then high for exactly
  // TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] ERR_DECODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE,
    ST_RELEASE
  } muxState_t;

  muxState_t                r_state;
  logic [NUM_SLAVES-1:0]    r_cyc;
  logic                     r_we;
  logic [ADR_WIDTH-1:0]     r_adr;
  logic [7:0]               r_wdat;
  logic [7:0]               r_rdat;
  logic                     r_ack;
  logic [7:0]               r_cnt;
  logic                     r_err;
  logic [1:0]               r_errCode;
  logic [ADR_WIDTH-1:0]     r_errAdr;

  muxState_t                w_stateNxt;
  logic [NUM_SLAVES-1:0]    w_cycNxt;
  logic                     w_weNxt;
  logic [ADR_WIDTH-1:0]     w_adrNxt;
  logic [7:0]               w_wdatNxt;
  logic [7:0]               w_rdatNxt;
  logic                     w_ackNxt;
  logic [7:0]               w_cntNxt;
  logic                     w_errSet;
  logic                     w_errNxt;
  logic [1:0]               w_errCodeNxt;
  logic [ADR_WIDTH-1:0]     w_errAdrNxt;

  logic [SEL_W-1:0]         w_sel;
  logic                     w_selOk;
  logic [NUM_SLAVES-1:0]    w_selHot;
  logic                     w_ackHit;
  logic [7:0]               w_slvDat;

  assign w_sel   = m_adr_i[ADR_WIDTH-1:SLV_ADR_WIDTH];
  assign w_selOk = (int'(w_sel) < NUM_SLAVES);

  // Only the ack of the slave currently being strobed counts. r_cyc is zero
  // outside ACTIVE, so stray acks from other slaves are masked off here.
  assign w_ackHit = |(s_ack_i & r_cyc);

  // Address decode into a one-hot select, and a read-data mux that is steered
  // by the registered one-hot cycle vector. No variable indexing is used, so
  // the mux stays in range for any legal NUM_SLAVES.
  always_comb begin
    w_selHot = '0;
    w_slvDat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_selHot[k] = (int'(w_sel) == k);
      if (r_cyc[k]) begin
        w_slvDat = w_slvDat | s_dat_i[8*k +: 8];
      end
    end
  end

  // Next-state and datapath logic for the transaction sequencer.
  // A decode error enters DONE with r_ack still low. DONE raises the ack on
  // its first cycle in that case, which gives the two-edge minimum latency.
  // Completions coming out of ACTIVE set the ack on the same edge, so the
  // master sees it directly after the slave ack or the watchdog expiry.
  always_comb begin
    w_stateNxt   = r_state;
    w_cycNxt     = r_cyc;
    w_weNxt      = r_we;
    w_adrNxt     = r_adr;
    w_wdatNxt    = r_wdat;
    w_rdatNxt    = r_rdat;
    w_ackNxt     = 1'b0;
    w_cntNxt     = r_cnt;
    w_errSet     = 1'b0;
    w_errCodeNxt = r_errCode;
    w_errAdrNxt  = r_errAdr;

    unique case (r_state)
      ST_IDLE: begin
        if (m_stb_i) begin
          w_weNxt   = m_we_i;
          w_adrNxt  = m_adr_i;
          w_wdatNxt = m_dat_i;
          if (w_selOk) begin
            w_cycNxt   = w_selHot;
            w_cntNxt   = 8'd0;
            w_stateNxt = ST_ACTIVE;
          end else begin
            w_rdatNxt    = 8'hFF;
            w_errSet     = 1'b1;
            w_errCodeNxt = ERR_DECODE;
            w_errAdrNxt  = m_adr_i;
            w_stateNxt   = ST_DONE;
          end
        end
      end

      ST_ACTIVE: begin
        // The ack is checked before the watchdog, so an ack that arrives on
        // the expiry edge still completes as a normal transfer.
        if (w_ackHit) begin
          w_cycNxt   = '0;
          w_rdatNxt  = w_slvDat;
          w_ackNxt   = 1'b1;
          w_stateNxt = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_cycNxt     = '0;
          w_rdatNxt    = 8'hFF;
          w_ackNxt     = 1'b1;
          w_errSet     = 1'b1;
          w_errCodeNxt = ERR_TIMEOUT;
          w_errAdrNxt  = r_adr;
          w_stateNxt   = ST_DONE;
        end else begin
          w_cntNxt = r_cnt + 8'd1;
        end
      end

      ST_DONE: begin
        if (!r_ack) begin
          w_ackNxt = 1'b1;
        end else begin
          w_stateNxt = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // A master that keeps its strobe high after the ack must not start
        // a second transfer, so wait for the strobe to drop first.
        if (!m_stb_i) begin
          w_stateNxt = ST_IDLE;
        end
      end

      default: begin
        w_stateNxt = ST_IDLE;
      end
    endcase

    // A new error has priority over a clear on the same edge.
    if (w_errSet) begin
      w_errNxt = 1'b1;
    end else if (err_clr_i) begin
      w_errNxt = 1'b0;
    end else begin
      w_errNxt = r_err;
    end
  end

  // State and datapath registers. All outputs come from these registers, so
  // reset forces every output to zero at once, including in mid-transfer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state   <= ST_IDLE;
      r_cyc     <= '0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= 8'd0;
      r_rdat    <= 8'd0;
      r_ack     <= 1'b0;
      r_cnt     <= 8'd0;
      r_err     <= 1'b0;
      r_errCode <= 2'b00;
      r_errAdr  <= '0;
    end else begin
      r_state   <= w_stateNxt;
      r_cyc     <= w_cycNxt;
      r_we      <= w_weNxt;
      r_adr     <= w_adrNxt;
      r_wdat    <= w_wdatNxt;
      r_rdat    <= w_rdatNxt;
      r_ack     <= w_ackNxt;
      r_cnt     <= w_cntNxt;
      r_err     <= w_errNxt;
      r_errCode <= w_errCodeNxt;
      r_errAdr  <= w_errAdrNxt;
    end
  end

  assign m_dat_o    = r_rdat;
  assign m_ack_o    = r_ack;
  assign s_cyc_o    = r_cyc;
  assign s_stb_o    = r_cyc;
  assign s_we_o     = r_we;
  assign s_adr_o    = r_adr[SLV_ADR_WIDTH-1:0];
  assign s_dat_o    = r_wdat;
  assign bus_err_o  = r_err;
  assign err_code_o = r_errCode;
  assign err_adr_o  = r_errAdr;

endmodule
